// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if
//   Control/status bundle for the ADSR envelope generator.
//   master: drives tick, gate, attackStep, decayStep, releaseStep, sustain;
//           observes env, envStrobe, stateOut, active.
//   slave : the envelope generator (opposite directions).
//   ACC_WIDTH must match the ACC_WIDTH of the connected adsr_envelope.
interface adsr_envelope_if #(
  parameter int unsigned ACC_WIDTH = 32
);
  logic                 tick;
  logic                 gate;
  logic [ACC_WIDTH-1:0] attackStep;
  logic [ACC_WIDTH-1:0] decayStep;
  logic [ACC_WIDTH-1:0] releaseStep;
  logic [15:0]          sustain;
  logic [15:0]          env;
  logic                 envStrobe;
  logic [2:0]           stateOut;
  logic                 active;

  modport master (
    output tick, gate, attackStep, decayStep, releaseStep, sustain,
    input  env, envStrobe, stateOut, active
  );

  modport slave (
    input  tick, gate, attackStep, decayStep, releaseStep, sustain,
    output env, envStrobe, stateOut, active
  );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope
//   Attack/decay/sustain/release envelope generator. The accumulator advances
//   only on cycles with bus.tick=1; results appear the following cycle
//   together with a one-cycle bus.envStrobe pulse.
// Ports:
//   Clk    - system clock, rising edge
//   Reset  - synchronous, active-high
//   bus    - adsr_envelope_if.slave: tick, gate, per-tick steps and sustain in;
//            env (acc top 16 bits), envStrobe, stateOut, active out
// Parameters:
//   ACC_WIDTH - accumulator width (>= 17)
// Configuration macro:
//   ADSR_HARD_RESTART_EN - when defined, every IDLE/RELEASE -> ATTACK
//   transition zeroes the accumulator; otherwise attack resumes from the
//   current level.
module adsr_envelope #(
  parameter int unsigned ACC_WIDTH = 32
) (
  input logic             Clk,
  input logic             Reset,
  adsr_envelope_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 gate_prev_q, gate_prev_d;
  logic                 strobe_q, strobe_d;

  logic                 rise;
  logic [ACC_WIDTH-1:0] sus_full;
  logic [ACC_WIDTH-1:0] att_lim;
  logic [ACC_WIDTH:0]   dec_lim;

  always_comb begin
    rise     = bus.gate & ~gate_prev_q;
    sus_full = {bus.sustain, {(ACC_WIDTH-16){1'b0}}};
    // acc > MAX - step is the no-wrap test for acc + step
    att_lim  = {ACC_WIDTH{1'b1}} - bus.attackStep;
    // one extra bit so an overflowing S + step is detected, not wrapped
    dec_lim  = {1'b0, sus_full} + {1'b0, bus.decayStep};
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    gate_prev_d = gate_prev_q;
    strobe_d    = bus.tick;

    if (bus.tick) begin
      gate_prev_d = bus.gate;
      unique case (state_q)
        IDLE: begin
          acc_d = '0;
          if (rise) state_d = ATTACK;
        end
        ATTACK, DECAY, SUSTAIN: begin
          // gate release takes precedence over any phase arithmetic
          if (!bus.gate) begin
            state_d = RELEASE;
          end else if (state_q == ATTACK) begin
            if (bus.attackStep == '0 || acc_q > att_lim) begin
              acc_d   = '1;
              state_d = DECAY;
            end else begin
              acc_d = acc_q + bus.attackStep;
            end
          end else if (state_q == DECAY) begin
            if (bus.decayStep == '0 || dec_lim[ACC_WIDTH] ||
                acc_q <= dec_lim[ACC_WIDTH-1:0]) begin
              acc_d   = sus_full;
              state_d = SUSTAIN;
            end else begin
              acc_d = acc_q - bus.decayStep;
            end
          end else begin
            acc_d = sus_full;
          end
        end
        RELEASE: begin
          if (rise) begin
            state_d = ATTACK;
`ifdef ADSR_HARD_RESTART_EN
            acc_d = '0;
`else
            acc_d = acc_q;
`endif
          end else if (bus.releaseStep == '0 || acc_q <= bus.releaseStep) begin
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = acc_q - bus.releaseStep;
          end
        end
        default: begin
          acc_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      gate_prev_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      gate_prev_q <= gate_prev_d;
      strobe_q    <= strobe_d;
    end
  end

  always_comb begin
    bus.env       = acc_q[ACC_WIDTH-1 -: 16];
    bus.envStrobe = strobe_q;
    bus.stateOut  = state_q;
    bus.active    = (state_q != IDLE);
  end

endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 Parameter: ACC_WIDTH, default 32, envelope accumulator width (minimum 17).
REQ-002 Clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 tick  in  1  sample-rate enable; envelope advances only on cycles where tick=1.
REQ-005 gate  in  1  note-on level; high = key held.
REQ-006 attackStep, decayStep, releaseStep  in  ACC_WIDTH each  per-tick accumulator increment/decrement; 0 = instantaneous phase.
REQ-007 sustain  in  16  sustain level; full-scale value is {sustain, zeros}.
REQ-008 env  out  16  envelope, acc[ACC_WIDTH-1 -: 16]; drives the oscillator env input.
REQ-009 envStrobe  out  1  one-cycle pulse, asserted the cycle after any tick.
REQ-010 stateOut  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-011 active  out  1  high when state != IDLE.

Function
REQ-012 Cycles with tick=0 shall hold acc, state and gatePrev unchanged.
REQ-013 On tick, rise = gate & ~gatePrev; gatePrev <= gate.
REQ-014 env, stateOut and active are derived from registers; an update made on a tick is visible the next cycle, coincident with envStrobe.
REQ-015 IDLE: acc=0; rise -> ATTACK, acc unchanged on the transition tick.
REQ-016 ATTACK/DECAY/SUSTAIN with gate=0 on a tick -> RELEASE, acc unchanged on that tick; this check has priority over arithmetic.
REQ-017 ATTACK: if attackStep=0 or acc > MAX-attackStep, then acc=MAX (all ones) -> DECAY; else acc += attackStep. No wrap.
REQ-018 DECAY: let S={sustain, zeros}. If decayStep=0, acc <= S+decayStep, or S+decayStep overflows, then acc=S -> SUSTAIN; else acc -= decayStep.
REQ-019 SUSTAIN: acc=S on every tick, tracking sustain changes; sustain=0 still holds SUSTAIN with active=1.
REQ-020 RELEASE: if releaseStep=0 or acc <= releaseStep, then acc=0 -> IDLE; else acc -= releaseStep. No underflow.
REQ-021 RELEASE with rise -> ATTACK (retrigger); the acc start value is per REQ-025.
REQ-022 Gate pulses that begin and end between ticks are not seen.

Reset
REQ-023 Reset shall set acc=0, state=IDLE, gatePrev=0 and envStrobe=0; the next cycle env=0x0000, stateOut=0, active=0.
REQ-024 Reset shall override tick in any state. A gate still high after Reset counts as rise on the first tick.

Configuration
REQ-025 Macro ADSR_HARD_RESTART_EN. Defined: every IDLE/RELEASE -> ATTACK transition sets acc=0 on the transition tick. Undefined: attack continues from the current acc (click-free legato).

Verification
REQ-026 ACC_WIDTH=32, tick every cycle, attackStep=0x4000_0000, gate 0->1 -> env over successive strobes 0000, 4000, 8000, C000, FFFF; stateOut 1 then 2 with env=FFFF.
REQ-027 From env=FFFF in DECAY, decayStep=0x1000_0000, sustain=0xC000 -> env EFFF, DFFF, CFFF, C000, stateOut=3 with env=C000; env then holds C000.
REQ-028 In SUSTAIN at C000, releaseStep=0x4000_0000, gate->0 -> env C000 (stateOut=4), 8000, 4000, 0000; active falls with env=0000.
REQ-029 Retrigger in RELEASE at env=8000, attackStep=0x4000_0000 -> macro undefined: 8000, C000, FFFF; macro defined: 0000, 4000, 8000.
REQ-030 Reset pulsed mid-ATTACK at env=8000 with gate held -> next cycle env=0000, stateOut=0, envStrobe=0; first tick after reset -> stateOut=1.
REQ-031 Gate high with all steps=0, sustain=0x8000; then tick=0 for 10 cycles -> ATTACK FFFF, DECAY 8000 on consecutive strobes; env, state and envStrobe=0 frozen while tick=0.
